// File: rtl/cdc_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_handshake_arbiter
//
// Source-domain controller that shares one 4-phase req/ack CDC channel between
// N_REQ requesters. A round-robin arbiter picks an owner, the owner's data word
// is captured and held on o_xfer_data, and the full 4-phase handshake is run
// against an acknowledge that is already synchronized into i_clk. Completion
// (or an abort after TIMEOUT_CYCLES without ack) is reported to the owner.
//
// Ports:
//   i_clk        source-domain clock
//   i_rst        asynchronous reset, active-high
//   i_req        per-requester level request, held until that requester's o_done
//   i_data       flat data, slice k = i_data[k*DATA_WIDTH +: DATA_WIDTH]
//   o_grant      one-hot channel owner (registered)
//   o_done       one-cycle completion pulse to the owner
//   o_timeout    one-cycle pulse with o_done when the transfer was aborted
//   o_xfer_req   4-phase request toward the destination domain (registered)
//   o_xfer_data  captured word, stable from grant until ack returns low
//   i_xfer_ack   destination acknowledge, already synchronized to i_clk
//   o_busy       high whenever the controller is not idle
// -----------------------------------------------------------------------------
module cdc_handshake_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]            o_grant,
  output logic [N_REQ-1:0]            o_done,
  output logic                        o_timeout,
  output logic                        o_xfer_req,
  output logic [DATA_WIDTH-1:0]       o_xfer_data,
  input  logic                        i_xfer_ack,
  output logic                        o_busy
);

  localparam int PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W     = (CNT_W_RAW > 0) ? CNT_W_RAW : 1;
  localparam bit TO_EN     = (TIMEOUT_CYCLES != 0);

  // Counter value seen on the TIMEOUT_CYCLES-th edge in REQ_WAIT (it is
  // cleared at grant, so edge k sees k-1).
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [PTR_W:0]   N_REQ_X  = (PTR_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ_WAIT,
    ST_ACK_WAIT,
    ST_DONE
  } state_t;

  // Registers
  state_t                r_state;
  logic [N_REQ-1:0]      r_grant;
  logic [N_REQ-1:0]      r_done;
  logic                  r_timeout;
  logic                  r_xfer_req;
  logic [DATA_WIDTH-1:0] r_xfer_data;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_abort;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_owner;

  // Next-state values
  state_t                w_state_next;
  logic [N_REQ-1:0]      w_grant_next;
  logic [N_REQ-1:0]      w_done_next;
  logic                  w_timeout_next;
  logic                  w_xfer_req_next;
  logic [DATA_WIDTH-1:0] w_xfer_data_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_abort_next;
  logic [PTR_W-1:0]      w_ptr_next;
  logic [PTR_W-1:0]      w_owner_next;

  // Arbitration
  logic [DATA_WIDTH-1:0] w_slice [N_REQ];
  logic [2*N_REQ-1:0]    w_req_dbl;
  logic [N_REQ-1:0]      w_req_rot;
  logic                  w_found;
  logic [PTR_W-1:0]      w_win_off;
  logic [PTR_W:0]        w_win_sum;
  logic [PTR_W:0]        w_win_diff;
  logic [PTR_W-1:0]      w_win_idx;
  logic [N_REQ-1:0]      w_win_onehot;
  logic [PTR_W-1:0]      w_ptr_inc;

  // Doubling the request vector turns "scan upward from the pointer with
  // wrap" into a plain lowest-set-bit search on a rotated window.
  assign w_req_dbl = {i_req, i_req};
  assign w_req_rot = w_req_dbl[r_ptr +: N_REQ];

  always_comb begin
    w_found   = 1'b0;
    w_win_off = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_req_rot[k]) begin
        w_found   = 1'b1;
        w_win_off = PTR_W'(k);
      end
    end
  end

  // Map the offset in the rotated window back to an absolute index.
  assign w_win_sum  = {1'b0, r_ptr} + {1'b0, w_win_off};
  assign w_win_diff = w_win_sum - N_REQ_X;
  assign w_win_idx  = (w_win_sum >= N_REQ_X) ? w_win_diff[PTR_W-1:0] : w_win_sum[PTR_W-1:0];

  assign w_ptr_inc  = (r_owner == PTR_LAST) ? '0 : r_owner + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_slice[gi]      = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_win_onehot[gi] = (w_win_idx == PTR_W'(gi));
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_done      <= '0;
      r_timeout   <= 1'b0;
      r_xfer_req  <= 1'b0;
      r_xfer_data <= '0;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      r_ptr       <= '0;
      r_owner     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_done      <= w_done_next;
      r_timeout   <= w_timeout_next;
      r_xfer_req  <= w_xfer_req_next;
      r_xfer_data <= w_xfer_data_next;
      r_cnt       <= w_cnt_next;
      r_abort     <= w_abort_next;
      r_ptr       <= w_ptr_next;
      r_owner     <= w_owner_next;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_done_next      = '0;
    w_timeout_next   = 1'b0;
    w_xfer_req_next  = r_xfer_req;
    w_xfer_data_next = r_xfer_data;
    w_cnt_next       = r_cnt;
    w_abort_next     = r_abort;
    w_ptr_next       = r_ptr;
    w_owner_next     = r_owner;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_next     = w_win_onehot;
          w_xfer_data_next = w_slice[w_win_idx];
          w_xfer_req_next  = 1'b1;
          w_cnt_next       = '0;
          w_owner_next     = w_win_idx;
          w_state_next     = ST_REQ_WAIT;
        end
      end

      ST_REQ_WAIT: begin
        // An ack arriving on the timeout edge wins over the abort.
        if (i_xfer_ack) begin
          w_xfer_req_next = 1'b0;
          w_state_next    = ST_ACK_WAIT;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_xfer_req_next = 1'b0;
          w_abort_next    = 1'b1;
          w_state_next    = ST_ACK_WAIT;
        end else if (r_cnt != CNT_SAT) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_ACK_WAIT: begin
        // No timeout here: a stuck-high ack intentionally parks the block.
        if (!i_xfer_ack) begin
          w_done_next    = r_grant;
          w_timeout_next = r_abort;
          w_state_next   = ST_DONE;
        end
      end

      ST_DONE: begin
        w_grant_next = '0;
        w_abort_next = 1'b0;
        w_ptr_next   = w_ptr_inc;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_grant     = r_grant;
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;
  assign o_xfer_req  = r_xfer_req;
  assign o_xfer_data = r_xfer_data;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for cdc_handshake_arbiter (N_REQ=4, DATA_WIDTH=8,
// TIMEOUT_CYCLES=16). Inputs change and outputs are sampled on the falling
// clock edge. Each check compares a snapshot of all outputs:
//   {o_grant[3:0], o_xfer_req, o_xfer_data[7:0], o_done[3:0], o_timeout, o_busy}
// -----------------------------------------------------------------------------
module tb_cdc_handshake_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic        i_xfer_ack;
  logic [3:0]  o_grant;
  logic [3:0]  o_done;
  logic        o_timeout;
  logic        o_xfer_req;
  logic [7:0]  o_xfer_data;
  logic        o_busy;

  logic [18:0] obs;
  int n_cmp;
  int n_err;

  assign obs = {o_grant, o_xfer_req, o_xfer_data, o_done, o_timeout, o_busy};

  cdc_handshake_arbiter #(
    .N_REQ(4),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req(i_req),
    .i_data(i_data),
    .o_grant(o_grant),
    .o_done(o_done),
    .o_timeout(o_timeout),
    .o_xfer_req(o_xfer_req),
    .o_xfer_data(o_xfer_data),
    .i_xfer_ack(i_xfer_ack),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse reset between scenarios so the round-robin pointer starts at 0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete transfer. Called at a falling edge with the block idle and
  // i_req set so that requester g wins at the next rising edge. Ack rises 3
  // cycles after o_xfer_req, drops 2 cycles after o_xfer_req falls. i_data is
  // scrambled during the transfer to show it is only sampled at the grant.
  task automatic do_transfer(input logic [3:0] g, input logic [7:0] d, input string tag);
    logic [18:0] exp_v;
    logic [31:0] saved;
    @(negedge clk);
    exp_v = {g, 1'b1, d, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s_grant: got %h expected %h", tag, obs, exp_v);
    end
    saved  = i_data;
    i_data = ~saved;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL %s_req_hold%0d: got %h expected %h", tag, k, obs, exp_v);
      end
    end
    i_xfer_ack = 1'b1;
    @(negedge clk);
    exp_v = {g, 1'b0, d, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s_req_fall: got %h expected %h", tag, obs, exp_v);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL %s_ack_high%0d: got %h expected %h", tag, k, obs, exp_v);
      end
    end
    i_xfer_ack = 1'b0;
    @(negedge clk);
    exp_v = {g, 1'b0, d, g, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s_done: got %h expected %h", tag, obs, exp_v);
    end
    i_req  = i_req & ~g;
    i_data = saved;
    @(negedge clk);
    exp_v = {4'b0000, 1'b0, d, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s_idle: got %h expected %h", tag, obs, exp_v);
    end
    $display("xfer %s: grant=%b data=%h done", tag, g, d);
  endtask

  task automatic test_reset();
    logic [18:0] exp_v;
    @(negedge clk);
    n_cmp++;
    if (obs !== 19'h0) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected %h", obs, 19'h0);
    end
    rst    = 1'b0;
    i_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    i_req  = 4'b0001;
    @(negedge clk);
    exp_v = {4'b0001, 1'b1, 8'h5A, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL reset_pre_grant: got %h expected %h", obs, exp_v);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 19'h0) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", obs, 19'h0);
    end
    @(negedge clk);
    rst   = 1'b0;
    i_req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 19'h0) begin
        n_err++;
        $display("FAIL reset_idle%0d: got %h expected %h", k, obs, 19'h0);
      end
    end
    $display("xfer reset: outputs cleared asynchronously, idle after release");
  endtask

  task automatic test_single();
    i_data = {8'h77, 8'h66, 8'hA5, 8'h55};
    i_req  = 4'b0010;
    do_transfer(4'b0010, 8'hA5, "single");
  endtask

  task automatic test_round_robin();
    do_reset();
    i_data = {8'h13, 8'h12, 8'h11, 8'h10};
    i_req  = 4'b1111;
    do_transfer(4'b0001, 8'h10, "rr0");
    do_transfer(4'b0010, 8'h11, "rr1");
    do_transfer(4'b0100, 8'h12, "rr2");
    do_transfer(4'b1000, 8'h13, "rr3");
    i_req = 4'b0000;
  endtask

  task automatic test_timeout();
    logic [18:0] exp_v;
    i_data     = {8'h33, 8'hC7, 8'h22, 8'h11};
    i_req      = 4'b0100;
    i_xfer_ack = 1'b0;
    @(negedge clk);
    exp_v = {4'b0100, 1'b1, 8'hC7, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL to_grant: got %h expected %h", obs, exp_v);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL to_wait_edge%0d: got %h expected %h", k, obs, exp_v);
      end
    end
    @(negedge clk);
    exp_v = {4'b0100, 1'b0, 8'hC7, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL to_req_fall: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = {4'b0100, 1'b0, 8'hC7, 4'b0100, 1'b1, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL to_done: got %h expected %h", obs, exp_v);
    end
    i_req = 4'b0000;
    @(negedge clk);
    exp_v = {4'b0000, 1'b0, 8'hC7, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL to_idle: got %h expected %h", obs, exp_v);
    end
    $display("xfer timeout: grant=0100 aborted after 16 edges");
  endtask

  // After the timeout on requester 2 the scan starts at 3; after 3 it wraps to 0.
  task automatic test_wrap();
    i_data = {8'h33, 8'hC7, 8'h22, 8'h11};
    i_req  = 4'b1001;
    do_transfer(4'b1000, 8'h33, "wrap3");
    i_req = 4'b1001;
    do_transfer(4'b0001, 8'h11, "wrap0");
    i_req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [18:0] exp_v;
    i_data = {8'h44, 8'h66, 8'h22, 8'h11};
    i_req  = 4'b0100;
    @(negedge clk);
    exp_v = {4'b0100, 1'b1, 8'h66, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL rmid_grant: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL rmid_req_wait: got %h expected %h", obs, exp_v);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 19'h0) begin
      n_err++;
      $display("FAIL rmid_async: got %h expected %h", obs, 19'h0);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== 19'h0) begin
      n_err++;
      $display("FAIL rmid_no_done: got %h expected %h", obs, 19'h0);
    end
    rst   = 1'b0;
    // Pointer must be back at 0: requester 0 beats requester 3.
    i_req = 4'b1001;
    do_transfer(4'b0001, 8'h11, "rmid_ptr0");
    do_transfer(4'b1000, 8'h44, "rmid_req3");
    i_req = 4'b0000;
  endtask

  // Ack arriving exactly on the 16th REQ_WAIT edge completes normally.
  task automatic test_timeout_boundary();
    logic [18:0] exp_v;
    i_data = {8'h44, 8'h66, 8'h22, 8'h9E};
    i_req  = 4'b0001;
    @(negedge clk);
    exp_v = {4'b0001, 1'b1, 8'h9E, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL tob_grant: got %h expected %h", obs, exp_v);
    end
    repeat (14) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL tob_edge15: got %h expected %h", obs, exp_v);
    end
    i_xfer_ack = 1'b1;
    @(negedge clk);
    exp_v = {4'b0001, 1'b0, 8'h9E, 4'b0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL tob_req_fall: got %h expected %h", obs, exp_v);
    end
    i_xfer_ack = 1'b0;
    @(negedge clk);
    exp_v = {4'b0001, 1'b0, 8'h9E, 4'b0001, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL tob_done: got %h expected %h", obs, exp_v);
    end
    i_req = 4'b0000;
    @(negedge clk);
    exp_v = {4'b0000, 1'b0, 8'h9E, 4'b0000, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL tob_idle: got %h expected %h", obs, exp_v);
    end
    $display("xfer timeout_boundary: ack on 16th edge, no timeout");
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    i_req      = 4'b0000;
    i_data     = 32'h0;
    i_xfer_ack = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_timeout_boundary();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_arbiter.md
Name: cdc_handshake_arbiter

Overview:
Source-domain controller that shares one 4-phase req/ack CDC channel between N_REQ requesters.
- Picks a requester by round-robin.
- Captures that requester's data word and drives the channel's request line.
- Completes the full 4-phase handshake against an acknowledge that an external 2-FF synchronizer has already brought into i_clk.
- Reports completion, or timeout, back to the requester.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, width of the word carried per transfer
TIMEOUT_CYCLES, 16, max cycles in REQ_WAIT without ack before abort; 0 disables timeout

Ports:
i_clk  input  1  source-domain clock
i_rst  input  1  asynchronous reset, active-high
i_req  input  N_REQ  per-requester level request; held until that requester sees its o_done
i_data  input  N_REQ*DATA_WIDTH  flat data, slice k = bits [k*DATA_WIDTH +: DATA_WIDTH]
o_grant  output  N_REQ  one-hot owner of the channel, registered
o_done  output  N_REQ  one-cycle completion pulse to owner
o_timeout  output  1  one-cycle pulse, coincident with o_done, when the transfer aborted
o_xfer_req  output  1  4-phase request to destination domain, registered
o_xfer_data  output  DATA_WIDTH  captured word, stable whenever o_xfer_req=1 and until ack returns low
i_xfer_ack  input  1  destination ack, already synchronized to i_clk
o_busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async assert, state applied immediately):
  - All outputs 0 and state IDLE.
  - rr pointer = 0; timeout counter = 0.
- States: IDLE, REQ_WAIT, ACK_WAIT, DONE.
- IDLE, when any i_req bit is high at the edge:
  - Choose the first set bit scanning from the pointer upward, wrapping N_REQ-1 -> 0.
  - Register o_grant = one-hot(winner), o_xfer_data = slice(winner), o_xfer_req = 1; clear counter; go to REQ_WAIT.
  - Latency: request seen at edge n gives grant and o_xfer_req high after edge n.
  - If no request, stay in IDLE.
- REQ_WAIT, normal path:
  - i_xfer_ack=1 at the edge: o_xfer_req <= 0, go to ACK_WAIT.
  - Otherwise increment counter.
- REQ_WAIT, timeout (TIMEOUT_CYCLES != 0):
  - If ack=0 on the TIMEOUT_CYCLES-th edge spent in REQ_WAIT: o_xfer_req <= 0, set abort flag, go to ACK_WAIT.
  - Ack=1 on that same edge wins: normal path, no timeout.
- ACK_WAIT: on an edge with i_xfer_ack=0, go to DONE and set o_done[winner]=1 (plus o_timeout=1 if the abort flag is set). There is no timeout in this state; a stuck-high ack holds the block here by design.
- DONE, one cycle:
  - o_done and o_timeout high for this cycle only.
  - At the exit edge: o_grant <= 0, abort flag cleared, pointer <= (winner+1) mod N_REQ; go to IDLE.
- Re-arbitration: IDLE lasts at least one edge after DONE, so a requester dropping i_req on the edge after o_done is never re-granted.
- o_xfer_data holds its last value after DONE and changes only on a new grant.
- Counter width is clog2(TIMEOUT_CYCLES+1), and the counter saturates.
- i_req changes while a transfer is active have no effect until the next IDLE arbitration.
- i_data is sampled only at the grant edge.
- Reset mid-transfer:
  - o_xfer_req drops immediately and all state clears.
  - No o_done is issued for the interrupted transfer.
  - The destination side must be reset together with this block.
- Minimum transfer with zero-delay ack: 4 edges from grant to the return to IDLE.

Test Plan:
- Reset, params N_REQ=4, DATA_WIDTH=8, TIMEOUT_CYCLES=16: assert i_rst mid-cycle -> all outputs 0 immediately; after release with i_req=0000, o_busy stays 0.
- i_req=0010, data slice1=0xA5, ack model raises ack 3 cycles after o_xfer_req and drops it 2 cycles after o_xfer_req falls -> o_grant=0010 and o_xfer_data=0xA5 for the whole transfer; o_xfer_req high until ack; single o_done=0010 pulse; o_timeout=0.
- i_req=1111 held, slices 0x10/0x11/0x12/0x13, requesters dropping req after their o_done -> grant order 0,1,2,3 with data 0x10..0x13; no requester is granted twice.
- Ack tied 0, i_req=0100 -> o_xfer_req falls after 16 edges in REQ_WAIT; o_done=0100 and o_timeout=1 in the same cycle; next grant starts the scan from index 3.
- Pointer wrap: complete a transfer for requester 3, then apply i_req=1001 -> grant 0001.
- i_rst asserted while in REQ_WAIT with o_xfer_req=1 -> o_xfer_req and o_grant go to 0 without a clock edge; no o_done; after release, i_req=1000 gives grant 1000 (pointer back at 0, scan 0..3).
